// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the default qualification length.
package debounce_pkg;

    // 10 ms of stable input at a 100 MHz clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1000000;

    // Debounce FSM states. The MSB encodes the accepted level and the LSB
    // marks a qualification window in progress.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops clear
// asynchronously on rst. Reusable for any slow asynchronous control input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of d into the clk domain; only q is safe to use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer. The raw button is synchronized, then a four-state
// FSM accepts a level change only after DEBOUNCE_CYCLES consecutive equal
// samples. level, press and release_pulse are all registered. The release
// pulse output is called release_pulse because "release" is a reserved word.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse
);

    // DEBOUNCE_CYCLES >= 2, so CNT_W >= 1 and CNT_W bits hold DEBOUNCE_CYCLES-1.
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic              sync_s;
    db_state_t         state_r;
    logic [CNT_W-1:0]  cnt_r;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (sync_s)
    );

    // Debounce FSM: qualify each departure from the accepted level and
    // emit a single-cycle press/release pulse on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= STABLE_LOW;
            cnt_r         <= CNT_ZERO;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // Pulses are only ever high for the one cycle they are set.
            press         <= 1'b0;
            release_pulse <= 1'b0;
            case (state_r)
                STABLE_LOW: begin
                    if (sync_s) begin
                        state_r <= WAIT_HIGH;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= STABLE_LOW;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_s) begin
                        // Bounce: drop all progress, no pulse.
                        state_r <= STABLE_LOW;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= STABLE_HIGH;
                        cnt_r   <= CNT_ZERO;
                        level   <= 1'b1;
                        press   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_s) begin
                        state_r <= WAIT_LOW;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= STABLE_HIGH;
                    end
                end
                WAIT_LOW: begin
                    if (sync_s) begin
                        // Bounce: drop all progress, no pulse.
                        state_r <= STABLE_HIGH;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r       <= STABLE_LOW;
                        cnt_r         <= CNT_ZERO;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to the safe low state.
                    state_r <= STABLE_LOW;
                    cnt_r   <= CNT_ZERO;
                    level   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4. Stimulus
// pushes the expected pulse kind and the cycle it must appear on; a monitor
// pops and compares whenever press or release_pulse is seen.
module tb_button_debounce;

    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    logic button;
    logic level;
    logic press;
    logic release_pulse;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit is_press;
        int at;
    } exp_t;

    exp_t sb[$];
    logic prev_level = 1'b0;

    button_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter; read on negedges, so the value is the last edge number.
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge right after changing button: the next posedge is
    // the first sampling edge S, and the pulse must appear on edge S+N+2.
    task automatic expect_pulse(input bit is_press);
        exp_t e;
        e.is_press = is_press;
        e.at       = cyc + 1 + N + 2;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Monitor: every pulse is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (press || release_pulse) begin
                vectors++;
                if (press && release_pulse) begin
                    miscompares++;
                    $display("FAIL overlap: press and release both high at cycle %0d", cyc);
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, none expected",
                             press, release_pulse, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_press !== press || e.at != cyc || level !== press) begin
                        miscompares++;
                        $display("FAIL pulse: got press=%b level=%b at cycle %0d, expected press=%b level=%b at cycle %0d",
                                 press, level, cyc, e.is_press, e.is_press, e.at);
                    end
                end
            end else if (!rst && level !== prev_level) begin
                vectors++;
                miscompares++;
                $display("FAIL level_no_pulse: level %b -> %b without pulse at cycle %0d",
                         prev_level, level, cyc);
            end
            prev_level = level;
        end
    end

    initial begin
        rst    = 1'b0;
        button = 1'b1;

        // Reset with button high, checked before any clock edge and across edges.
        #1 rst = 1'b1;
        #1;
        check("reset_async_level",   level,         1'b0);
        check("reset_async_press",   press,         1'b0);
        check("reset_async_release", release_pulse, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_level", level, 1'b0);
            check("reset_press", press, 1'b0);
        end

        // Button held across reset release: one press after full qualification.
        rst = 1'b0;
        expect_pulse(1'b1);
        tick(20);

        // Clean release.
        button = 1'b0;
        expect_pulse(1'b0);
        tick(20);

        // Clean press and release.
        button = 1'b1;
        expect_pulse(1'b1);
        tick(20);
        button = 1'b0;
        expect_pulse(1'b0);
        tick(20);

        // Glitch shorter than qualification: nothing happens.
        button = 1'b1;
        tick(3);
        button = 1'b0;
        tick(20);
        check("glitch_level", level, 1'b0);

        // Bouncy press: 1,0,1,0,1 then held high.
        button = 1'b1; tick(1);
        button = 1'b0; tick(1);
        button = 1'b1; tick(1);
        button = 1'b0; tick(1);
        button = 1'b1;
        expect_pulse(1'b1);
        tick(20);
        check("bounce_press_level", level, 1'b1);

        // Bouncy release: 0,1,0 then held low.
        button = 1'b0; tick(1);
        button = 1'b1; tick(1);
        button = 1'b0;
        expect_pulse(1'b0);
        tick(20);
        check("bounce_release_level", level, 1'b0);

        // Ten press/release cycles.
        for (int i = 0; i < 10; i++) begin
            button = 1'b1;
            expect_pulse(1'b1);
            tick(10);
            button = 1'b0;
            expect_pulse(1'b0);
            tick(10);
        end

        // Reset two cycles into qualification: progress discarded.
        button = 1'b1;
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midqual_rst_press", press, 1'b0);
            check("midqual_rst_level", level, 1'b0);
        end
        rst = 1'b0;
        expect_pulse(1'b1);
        tick(20);
        check("midqual_level", level, 1'b1);

        // Asynchronous reset while high clears level between clock edges.
        #2 rst = 1'b1;
        #1 check("async_rst_level_high", level, 1'b0);
        tick(2);
        rst = 1'b0;
        expect_pulse(1'b1);
        tick(20);
        button = 1'b0;
        expect_pulse(1'b0);
        tick(20);

        // Every expected pulse must have been consumed.
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), legal range >= 2; the number of consecutive stable synchronized samples required to accept a level change.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port button  input  1  raw mechanical push-button, asynchronous to clk, bouncy.
REQ-005 SHALL have port level  output  1  debounced button level, registered.
REQ-006 SHALL have port press  output  1  one-cycle pulse on each accepted 0->1 transition of level.
REQ-007 SHALL have port release  output  1  one-cycle pulse on each accepted 1->0 transition of level.

Function
REQ-008 SHALL pass button through a 2-flop synchronizer; FSM logic sees only the second flop output (sync).
REQ-009 SHALL implement FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-010 STABLE_LOW: sync=1 -> WAIT_HIGH with cnt<=0; otherwise stay.
REQ-011 WAIT_HIGH: sync=0 -> STABLE_LOW, cnt<=0, no pulse; sync=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level<=1, press<=1; otherwise cnt<=cnt+1.
REQ-012 STABLE_HIGH: sync=0 -> WAIT_LOW with cnt<=0; otherwise stay.
REQ-013 WAIT_LOW: sync=1 -> STABLE_HIGH, cnt<=0, no pulse; sync=0 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_LOW, level<=0, release<=1; otherwise cnt<=cnt+1.
REQ-014 press and release SHALL be high for exactly one clk cycle per accepted transition and never high simultaneously.
REQ-015 Latency: a clean raw edge SHALL change level DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it; press/release assert on the same edge as level.
REQ-016 Any sync excursion shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave level, press, release unchanged.
REQ-017 Bounce during WAIT_* SHALL restart qualification from cnt=0 on the next departure; no partial credit carried over.
REQ-018 cnt width SHALL be clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-019 level SHALL be a registered output, glitch-free, suitable as the clock/enable of a downstream toggle stage; press SHALL be usable as a synchronous toggle enable.

Reset
REQ-020 rst=1 SHALL immediately force state=STABLE_LOW, cnt=0, level=0, press=0, release=0, both synchronizer flops=0, independent of clk.
REQ-021 Reset asserted mid-qualification SHALL discard progress; a button held high across reset release SHALL produce one press after full qualification, DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Structure
REQ-022 FSM state encoding and the default DEBOUNCE_CYCLES constant SHALL live in shared package debounce_pkg.
REQ-023 The synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reusable for other asynchronous inputs.
REQ-024 Implementation SHALL be 120-400 lines of synthesizable RTL, no latches, no gated clocks.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Reset: rst=1 with button=1 -> level=0, press=0, release=0 while asserted, regardless of clk.
REQ-026 Clean press: button 0->1 held 20 cycles -> level=1 and press=1 for exactly one cycle, 6 edges after first sampling edge; release stays 0.
REQ-027 Glitch: button high for 3 cycles then low -> level, press, release never change.
REQ-028 Bounce: button toggles 1,0,1,0,1 (one cycle each) then held high -> exactly one press, 6 edges after the final rising sample.
REQ-029 Release: from level=1, button 1->0 held -> level=0 with single release pulse after 6 edges; 10 press/release cycles -> 10 press and 10 release pulses, never overlapping.
REQ-030 Mid-qualification reset: button held high, rst pulsed 2 cycles after button rise -> no press during reset; single press 6 edges after rst deasserts.
